code2of5_scan_ctrl: RTL and testbench

- Time-multiplexed display controller. It owns one shared 2-of-5 → 7-segment decoder (segment modules SegmentoA..G fed by E1..E5) and shares it across NUM_DIGITS common-anode digits.
- Holds one 5-bit 2-of-5 code per digit, validates each code on write, and steps the shared decoder input through the digits.
- Inserts a blanking gap between digits so no ghosting occurs.
- Sits between the code source (keypad/encoder logic) and the display pins.

---
 rtl/code2of5_scan_ctrl_pkg.sv | 21 ++
 rtl/code2of5_scan_ctrl_if.sv | 28 ++
 rtl/code2of5_scan_ctrl_scan_timer.sv | 32 +++
 rtl/code2of5_scan_ctrl.sv | 119 +++++++++++
 tb/tb_code2of5_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/code2of5_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 2-of-5 display controller.
package code2of5_scan_ctrl_pkg;

  localparam int unsigned CODE_W = 5;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic valid_2of5(input logic [CODE_W-1:0] code);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      ones += 32'(code[i]);
    end
    return (ones == 2);
  endfunction

endpackage

// File: rtl/code2of5_scan_ctrl_if.sv
// Code-write and display-drive signal bundle between code source and controller.
interface code2of5_scan_ctrl_if
  import code2of5_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();
  localparam int ADDR_W = $clog2(NUM_DIGITS);

  logic                  en;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [CODE_W-1:0]     wr_code;
  logic                  wr_ack;
  logic [CODE_W-1:0]     dec_code;
  logic [NUM_DIGITS-1:0] digit_en_n;
  logic [NUM_DIGITS-1:0] err;
  logic [ADDR_W-1:0]     scan_idx;

  modport master (
    output en, wr_en, wr_addr, wr_code,
    input  wr_ack, dec_code, digit_en_n, err, scan_idx
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_code,
    output wr_ack, dec_code, digit_en_n, err, scan_idx
  );
endinterface

// File: rtl/code2of5_scan_ctrl_scan_timer.sv
// Phase cycle counter: counts while run is high and pulses tc on the last
// cycle of the current phase (DRIVE or GAP), then restarts from zero.
module code2of5_scan_ctrl_scan_timer #(
  parameter int DRIVE_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sel_gap,
  output logic tc
);
  localparam int MAX_CYCLES = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = run && (cnt_q == (sel_gap ? GAP_LAST : DRIVE_LAST));
    cnt_d = (!run || tc) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/code2of5_scan_ctrl.sv
// Time-multiplexed 2-of-5 display controller: stores one code per digit,
// flags invalid codes and steps a shared decoder through the digits with gaps.
module code2of5_scan_ctrl
  import code2of5_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500
) (
  input logic                clk,
  input logic                rst,
  code2of5_scan_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_DIGITS);
  localparam logic [ADDR_W:0]   NUM_DIGITS_L = (ADDR_W + 1)'(NUM_DIGITS);
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     scan_idx_q, scan_idx_d;
  logic [CODE_W-1:0]     code_q [NUM_DIGITS];
  logic [CODE_W-1:0]     code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] err_q, err_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [CODE_W-1:0]     dec_code_q, dec_code_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;

  logic wr_hit;
  logic timer_run;
  logic timer_sel_gap;
  logic tc;

  code2of5_scan_ctrl_scan_timer #(
    .DRIVE_CYCLES (DRIVE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (timer_run),
    .sel_gap (timer_sel_gap),
    .tc      (tc)
  );

  always_comb begin
    timer_run     = bus.en && (state_q != ST_OFF);
    timer_sel_gap = (state_q == ST_GAP);
  end

  // Code registers and per-digit validity flags.
  always_comb begin
    wr_hit   = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_DIGITS_L);
    code_d   = code_q;
    err_d    = err_q;
    wr_ack_d = wr_hit;
    if (wr_hit) begin
      code_d[bus.wr_addr] = bus.wr_code;
      err_d[bus.wr_addr]  = ~valid_2of5(bus.wr_code);
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    case (state_q)
      ST_OFF: begin
        if (bus.en) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!bus.en)  state_d = ST_OFF;
        else if (tc)  state_d = ST_GAP;
      end
      ST_GAP: begin
        if (!bus.en) begin
          state_d = ST_OFF;
        end else if (tc) begin
          state_d    = ST_DRIVE;
          scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs follow the next state so anode and decoder switch on the same edge
  // as the state; stored codes are read pre-write, giving one cycle of write latency.
  always_comb begin
    digit_en_n_d = '1;
    dec_code_d   = '0;
    if (state_d == ST_DRIVE) begin
      digit_en_n_d[scan_idx_d] = 1'b0;
      if (!err_q[scan_idx_d]) dec_code_d = code_q[scan_idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      scan_idx_q   <= '0;
      code_q       <= '{default: '0};
      err_q        <= '0;
      wr_ack_q     <= 1'b0;
      dec_code_q   <= '0;
      digit_en_n_q <= '1;
    end else begin
      state_q      <= state_d;
      scan_idx_q   <= scan_idx_d;
      code_q       <= code_d;
      err_q        <= err_d;
      wr_ack_q     <= wr_ack_d;
      dec_code_q   <= dec_code_d;
      digit_en_n_q <= digit_en_n_d;
    end
  end

  assign bus.wr_ack     = wr_ack_q;
  assign bus.dec_code   = dec_code_q;
  assign bus.digit_en_n = digit_en_n_q;
  assign bus.err        = err_q;
  assign bus.scan_idx   = scan_idx_q;
endmodule

// File: tb/tb_code2of5_scan_ctrl.sv
// Self-checking bench for code2of5_scan_ctrl: a 4-digit build for the main
// scenarios and a 5-digit build for out-of-range addresses and odd wrap.
module tb_code2of5_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  code2of5_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  code2of5_scan_ctrl_if #(.NUM_DIGITS(5)) bus5 ();

  code2of5_scan_ctrl #(.NUM_DIGITS(4), .DRIVE_CYCLES(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  code2of5_scan_ctrl #(.NUM_DIGITS(5), .DRIVE_CYCLES(4), .GAP_CYCLES(1)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  // One scoreboard entry: stimulus for one edge plus the outputs expected after it.
  typedef struct packed {
    logic       en_in;
    logic       wr;
    logic [1:0] addr;
    logic [4:0] code;
    logic [4:0] dec;
    logic [3:0] en_n;
    logic [1:0] idx;
    logic       ack;
  } ent_t;

  ent_t sb[$];

  localparam logic [4:0] C0 = 5'b11000;
  localparam logic [4:0] C1 = 5'b01001;
  localparam logic [4:0] C2 = 5'b10001;
  localparam logic [4:0] C3 = 5'b00011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(logic en_in, logic drive, logic [1:0] idx,
                              logic [4:0] dec, logic ack);
    ent_t e;
    logic [3:0] one;
    one     = 4'b0001;
    e       = '0;
    e.en_in = en_in;
    e.idx   = idx;
    e.ack   = ack;
    e.en_n  = drive ? ~(one << idx) : 4'b1111;
    e.dec   = drive ? dec : 5'b00000;
    return e;
  endfunction

  function automatic void push_slot(logic [1:0] idx, logic [4:0] dec);
    for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, 1'b1, idx, dec, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, idx, 5'b0, 1'b0));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    tick();
    tick();
    checks++; if (bus.digit_en_n !== 4'b1111) begin errors++; $display("FAIL reset_en_n: got %b want 1111", bus.digit_en_n); end
    checks++; if (bus.dec_code !== 5'b0) begin errors++; $display("FAIL reset_dec: got %b want 00000", bus.dec_code); end
    checks++; if (bus.err !== 4'b0) begin errors++; $display("FAIL reset_err: got %b want 0000", bus.err); end
    checks++; if (bus.scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.scan_idx); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wr_ack); end
    rst = 1'b0;
    tick();
    checks++; if (bus.digit_en_n !== 4'b1110) begin errors++; $display("FAIL reset_release_en_n: got %b want 1110", bus.digit_en_n); end
    checks++; if (bus.dec_code !== 5'b0) begin errors++; $display("FAIL reset_release_dec: got %b want 00000", bus.dec_code); end
    bus.en = 1'b0;
    tick();
    checks++; if (bus.digit_en_n !== 4'b1111) begin errors++; $display("FAIL reset_off_en_n: got %b want 1111", bus.digit_en_n); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] codes [4];
    codes = '{C0, C1, C2, C3};
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_code = codes[i];
      tick();
      checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, bus.wr_ack); end
    end
    bus.wr_en = 1'b0;
    tick();
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %b want 0", bus.wr_ack); end
    checks++; if (bus.err !== 4'b0) begin errors++; $display("FAIL b2b_err: got %b want 0000", bus.err); end
  endtask

  task automatic test_scan();
    ent_t e;
    int   n = 0;
    push_slot(2'd0, C0);
    push_slot(2'd1, C1);
    push_slot(2'd2, C2);
    push_slot(2'd3, C3);
    sb.push_back(mk(1'b1, 1'b1, 2'd0, C0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'b0, 1'b0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.en = e.en_in; bus.wr_en = e.wr; bus.wr_addr = e.addr; bus.wr_code = e.code;
      tick();
      checks++;
      if ({bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack} !== {e.dec, e.en_n, e.idx, e.ack}) begin
        errors++;
        $display("FAIL scan step %0d: dec=%b en_n=%b idx=%0d ack=%b, want dec=%b en_n=%b idx=%0d ack=%b",
                 n, bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack, e.dec, e.en_n, e.idx, e.ack);
      end
      n++;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_invalid();
    ent_t e;
    int   n = 0;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_code = 5'b11100;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.err !== 4'b0100) begin errors++; $display("FAIL invalid_err: got %b want 0100", bus.err); end
    checks++; if (bus.wr_ack !== 1'b1) begin errors++; $display("FAIL invalid_ack: got %b want 1", bus.wr_ack); end
    push_slot(2'd0, C0);
    push_slot(2'd1, C1);
    push_slot(2'd2, 5'b00000);
    push_slot(2'd3, C3);
    sb.push_back(mk(1'b1, 1'b1, 2'd0, C0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 2'd0, 5'b0, 1'b0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.en = e.en_in; bus.wr_en = e.wr; bus.wr_addr = e.addr; bus.wr_code = e.code;
      tick();
      checks++;
      if ({bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack} !== {e.dec, e.en_n, e.idx, e.ack}) begin
        errors++;
        $display("FAIL invalid step %0d: dec=%b en_n=%b idx=%0d ack=%b, want dec=%b en_n=%b idx=%0d ack=%b",
                 n, bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack, e.dec, e.en_n, e.idx, e.ack);
      end
      n++;
    end
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_code = 5'b00101;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL invalid_clear_err: got %b want 0000", bus.err); end
  endtask

  task automatic test_live_write();
    ent_t e;
    int   n = 0;
    push_slot(2'd0, C0);
    sb.push_back(mk(1'b1, 1'b1, 2'd1, C1, 1'b0));
    e = mk(1'b1, 1'b1, 2'd1, C1, 1'b1);
    e.wr = 1'b1; e.addr = 2'd1; e.code = 5'b10100;
    sb.push_back(e);
    sb.push_back(mk(1'b1, 1'b1, 2'd1, 5'b10100, 1'b0));
    sb.push_back(mk(1'b1, 1'b1, 2'd1, 5'b10100, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 2'd1, 5'b0, 1'b0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.en = e.en_in; bus.wr_en = e.wr; bus.wr_addr = e.addr; bus.wr_code = e.code;
      tick();
      checks++;
      if ({bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack} !== {e.dec, e.en_n, e.idx, e.ack}) begin
        errors++;
        $display("FAIL live_write step %0d: dec=%b en_n=%b idx=%0d ack=%b, want dec=%b en_n=%b idx=%0d ack=%b",
                 n, bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack, e.dec, e.en_n, e.idx, e.ack);
      end
      n++;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_pause();
    ent_t e;
    int   n = 0;
    for (int k = 0; k < 2; k++) sb.push_back(mk(1'b1, 1'b1, 2'd2, 5'b00101, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 2'd2, 5'b0, 1'b0));
    push_slot(2'd2, 5'b00101);
    sb.push_back(mk(1'b1, 1'b1, 2'd3, C3, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 2'd3, 5'b0, 1'b0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.en = e.en_in; bus.wr_en = e.wr; bus.wr_addr = e.addr; bus.wr_code = e.code;
      tick();
      checks++;
      if ({bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack} !== {e.dec, e.en_n, e.idx, e.ack}) begin
        errors++;
        $display("FAIL pause step %0d: dec=%b en_n=%b idx=%0d ack=%b, want dec=%b en_n=%b idx=%0d ack=%b",
                 n, bus.dec_code, bus.digit_en_n, bus.scan_idx, bus.wr_ack, e.dec, e.en_n, e.idx, e.ack);
      end
      n++;
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [4:0] one5;
    logic [4:0] exp_en_n;
    logic [4:0] exp_dec;
    int slot, ph, idx;
    one5 = 5'b00001;
    bus5.wr_en = 1'b1; bus5.wr_addr = 3'd4; bus5.wr_code = C3;
    tick();
    checks++; if (bus5.wr_ack !== 1'b1) begin errors++; $display("FAIL oor_valid_ack: got %b want 1", bus5.wr_ack); end
    bus5.wr_addr = 3'd5; bus5.wr_code = 5'b11111;
    tick();
    checks++; if (bus5.wr_ack !== 1'b0) begin errors++; $display("FAIL oor_addr5_ack: got %b want 0", bus5.wr_ack); end
    bus5.wr_addr = 3'd7; bus5.wr_code = 5'b11100;
    tick();
    checks++; if (bus5.wr_ack !== 1'b0) begin errors++; $display("FAIL oor_addr7_ack: got %b want 0", bus5.wr_ack); end
    checks++; if (bus5.err !== 5'b0) begin errors++; $display("FAIL oor_err: got %b want 00000", bus5.err); end
    bus5.wr_en = 1'b0;
    bus5.en = 1'b1;
    // Reference sequence: 5 edges per digit (4 lit, 1 gap); only digit 4 holds a code.
    for (int k = 1; k <= 27; k++) begin
      tick();
      slot = (k - 1) / 5;
      ph   = (k - 1) % 5;
      idx  = slot % 5;
      exp_en_n = (ph < 4) ? ~(one5 << idx) : 5'b11111;
      exp_dec  = (ph < 4 && idx == 4) ? C3 : 5'b00000;
      checks++;
      if ({bus5.dec_code, bus5.digit_en_n, bus5.scan_idx} !== {exp_dec, exp_en_n, 3'(idx)}) begin
        errors++;
        $display("FAIL oor_scan edge %0d: dec=%b en_n=%b idx=%0d, want dec=%b en_n=%b idx=%0d",
                 k, bus5.dec_code, bus5.digit_en_n, bus5.scan_idx, exp_dec, exp_en_n, idx);
      end
    end
    bus5.en = 1'b0;
    tick();
  endtask

  task automatic test_reset_write();
    rst = 1'b1; bus.en = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_code = C3;
    tick();
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL rst_write_ack: got %b want 0", bus.wr_ack); end
    checks++; if (bus.digit_en_n !== 4'b1111) begin errors++; $display("FAIL rst_write_en_n: got %b want 1111", bus.digit_en_n); end
    checks++; if (bus.scan_idx !== 2'd0) begin errors++; $display("FAIL rst_write_idx: got %0d want 0", bus.scan_idx); end
    rst = 1'b0; bus.wr_en = 1'b0;
    tick();
    checks++; if (bus.digit_en_n !== 4'b1110) begin errors++; $display("FAIL rst_write_drive_en_n: got %b want 1110", bus.digit_en_n); end
    checks++; if (bus.dec_code !== 5'b00000) begin errors++; $display("FAIL rst_write_discarded: dec got %b want 00000", bus.dec_code); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL rst_write_late_ack: got %b want 0", bus.wr_ack); end
    bus.en = 1'b0;
    tick();
  endtask

  initial begin
    bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_code = '0;
    bus5.en = 1'b0; bus5.wr_en = 1'b0; bus5.wr_addr = '0; bus5.wr_code = '0;
    test_reset();
    test_back_to_back();
    test_scan();
    test_invalid();
    test_live_write();
    test_pause();
    test_out_of_range();
    test_reset_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
